data_mem: RTL and testbench
===========================

Name: data_mem

Overview:
- Single-port, byte-wide data memory for the RISC datapath; used by the execute/memory stage for load/store.
- 256 x 8-bit storage array, addressed by an 8-bit address.
- Synchronous write on rising clk; asynchronous (combinational) read of the addressed word.
- Synchronous active-low reset clears the whole array.

Parameters:
- ADDR_W, 8, address width; depth = 2**ADDR_W words (default 256).
- DATA_W, 8, word width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- address  input  ADDR_W  word address for both read and write.
- write_data  input  DATA_W  data stored on a write cycle.
- wren  input  1  write strobe, ACTIVE-LOW: 0 = write, 1 = read only.
- read_data  output  DATA_W  current contents of mem[address].

Behaviour:
- Storage: mem[0 .. 2**ADDR_W-1], each DATA_W bits.
- Reset: on a rising clk with rst_n=0, every mem entry becomes 0.
  - wren is ignored during reset; reset has priority over write.
  - read_data is therefore 0 for any address from the cycle after reset is sampled.
- Write: on a rising clk with rst_n=1 and wren=0, mem[address] <= write_data.
  - Exactly one word is written per cycle; all other words are unchanged.
- No write: with wren=1, the array is unchanged regardless of write_data.
- Read: read_data = mem[address] combinationally, with zero-cycle latency.
  - Changes on address change without waiting for clk.
  - After a write, read_data reflects the new value immediately after that clock edge (same address).
  - Within the write cycle, before the edge, read_data shows the old contents (read-before-write).
- No X propagation from reset state: all entries are defined after the first reset.
  - Before any reset, contents are undefined.
- Address covers the full range; there is no out-of-range case and no wrap logic.
- wren, address and write_data are sampled only at the rising edge for writes.
  - Glitches between edges do not corrupt memory.

Decomposition:
- Shared package holds ADDR_W/DATA_W defaults (MEM_ADDR_W=8, MEM_DATA_W=8), reused by the execute stage and register/memory interfaces.
- No sub-module is required. Optional: a generic sp_ram_async_rd array wrapped by data_mem, which adds the reset-clear and the active-low wren decode.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release -> read_data=0x00 at addresses 0, 1, 2, 3 and 255.
- Basic writes (period 100, stimulus changes 10 before each posedge):
  - addr0/0x21/wren=0 -> mem[0]=0x21
  - addr1/0x43/wren=0 -> mem[1]=0x43
- Masked write:
  - addr2/0x65/wren=1 -> mem[2] stays 0x00 (read_data=0x00 after the edge).
  - Next cycle: addr2/0x87/wren=0 -> read_data=0x87 after the edge.
  - Then addr3/0xa9/wren=0 -> mem[3]=0xa9.
- Readback with wren=1 and write_data held at 0xa9:
  - addresses 0,1,2,3 -> 0x21, 0x43, 0x87, 0xa9, each visible combinationally on address change.
  - No entry is overwritten with 0xa9.
- Read-before-write: address=5 holding 0x11, write_data=0x22, wren=0 -> read_data=0x11 before the edge, 0x22 after.
- Reset priority: rst_n=0 with wren=0, addr=1, data=0xff -> mem[1]=0x00, not 0xff. Then rst_n=1 -> all previous data is cleared.

Source files
------------

// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared sizing for the datapath data memory. The execute stage and the
// register/memory interfaces reuse these defaults so every consumer agrees on
// the address and word widths.
// -----------------------------------------------------------------------------
package data_mem_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  // Number of words addressable with an aw-bit address.
  function automatic int mem_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage : data_mem_pkg

// File: rtl/data_mem_array.sv
// -----------------------------------------------------------------------------
// data_mem_array
// Generic single-port storage array with a synchronous whole-array clear,
// an active-high write enable and a combinational read port.
//
// Ports:
//   clk    in   system clock, all state changes on the rising edge
//   clear  in   synchronous clear of every word (wins over a write)
//   we     in   write enable, active-high
//   addr   in   word address shared by read and write
//   wdata  in   data stored when we=1
//   rdata  out  mem[addr], combinational (old contents until the write edge)
// -----------------------------------------------------------------------------
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = mem_depth(ADDR_W);

  // Held in flops rather than block RAM: a single-cycle clear of every word
  // and a zero-latency read are both outside what a RAM primitive offers.
  logic [DATA_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we) begin
      mem_reg[addr] <= wdata;
    end
  end

  // The full address range maps onto DEPTH words, so no bounds handling.
  assign rdata = mem_reg[addr];

endmodule : data_mem_array

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Byte-wide data memory used by the execute/memory stage for loads and
// stores. Wraps the generic array, adding the active-low reset and the
// active-low write strobe decode.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous reset, active-low; clears every word
//   address     in   word address for both read and write
//   write_data  in   data stored on a write cycle
//   wren        in   write strobe, active-low (0 = write, 1 = read only)
//   read_data   out  current contents of mem[address], combinational
// -----------------------------------------------------------------------------
module data_mem
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              wren,
  output logic [DATA_W-1:0] read_data
);

  logic clear;
  logic we;

  // Reset takes priority inside the array, so a write strobe during reset
  // is discarded rather than landing after the clear.
  assign clear = ~rst_n;
  assign we    = ~wren;

  data_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .clear (clear),
    .we    (we),
    .addr  (address),
    .wdata (write_data),
    .rdata (read_data)
  );

endmodule : data_mem

// File: tb/tb_data_mem.sv
// -----------------------------------------------------------------------------
// tb_data_mem
// Directed self-checking bench for data_mem. Expected values come from a
// bench-side model of the memory and are queued when stimulus is driven,
// then popped and compared when the DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_data_mem;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic          wren;
  logic [DW-1:0] read_data;

  data_mem #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .write_data (write_data),
    .wren       (wren),
    .read_data  (read_data)
  );

  // Period 100: rising edges at 50, 150, 250, ...
  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    logic [DW-1:0] exp;
    string         tag;
  } sb_entry_t;

  sb_entry_t     sb_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            checks   = 0;
  int            failures = 0;

  task automatic sb_push(input logic [DW-1:0] exp, input string tag);
    sb_entry_t e;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Compare the current DUT output against the oldest queued expectation.
  task automatic sb_check();
    sb_entry_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%02h expected=<queued value>", read_data);
    end else begin
      e = sb_q.pop_front();
      assert (read_data === e.exp)
      else begin
        failures++;
        $error("FAIL %s observed=%02h expected=%02h", e.tag, read_data, e.exp);
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // One clocked transaction: inputs change 10 before the edge, the old
  // contents are checked 5 before the edge and the result 1 after it.
  task automatic drive_cycle(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic w, input string name);
    @(negedge clk);
    #40;
    address    = a;
    write_data = d;
    wren       = w;
    sb_push(model_mem[a], {name, "_before_edge"});
    #5;
    sb_check();
    if (!w) model_mem[a] = d;
    sb_push(model_mem[a], {name, "_after_edge"});
    @(posedge clk);
    #1;
    sb_check();
    $display("txn %s addr=%02h data=%02h wren=%0b read_data=%02h",
             name, a, d, w, read_data);
  endtask

  // Combinational read of one address, no clock involved.
  task automatic read_addr(input logic [AW-1:0] a, input string name);
    address = a;
    sb_push(model_mem[a], name);
    #1;
    sb_check();
  endtask

  task automatic scan_all(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      read_addr(AW'(i), name);
    end
    $display("txn scan %s over %0d words", name, DEPTH);
  endtask

  initial begin
    rst_n      = 1'b0;
    wren       = 1'b1;
    address    = '0;
    write_data = '0;

    // Reset held for two rising edges, released between edges.
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    read_addr(8'd0,   "reset_a0");
    read_addr(8'd1,   "reset_a1");
    read_addr(8'd2,   "reset_a2");
    read_addr(8'd3,   "reset_a3");
    read_addr(8'd255, "reset_a255");
    $display("txn reset released");

    // Basic writes, a masked write, then a real write to the same word.
    drive_cycle(8'd0, 8'h21, 1'b0, "write_a0");
    drive_cycle(8'd1, 8'h43, 1'b0, "write_a1");
    drive_cycle(8'd2, 8'h65, 1'b1, "masked_a2");
    drive_cycle(8'd2, 8'h87, 1'b0, "write_a2");
    drive_cycle(8'd3, 8'ha9, 1'b0, "write_a3");

    // Readback with write_data parked at 0xa9 and wren high.
    @(negedge clk);
    wren       = 1'b1;
    write_data = 8'ha9;
    read_addr(8'd0, "readback_a0");
    read_addr(8'd1, "readback_a1");
    read_addr(8'd2, "readback_a2");
    read_addr(8'd3, "readback_a3");
    $display("txn readback a0..a3");
    scan_all("no_overwrite");

    // Read-before-write on address 5.
    drive_cycle(8'd5, 8'h11, 1'b0, "prep_a5");
    drive_cycle(8'd5, 8'h22, 1'b0, "rbw_a5");

    // Top address boundary.
    drive_cycle(8'd255, 8'h5a, 1'b0, "write_a255");
    read_addr(8'd0, "after_a255_a0");

    // A write strobe pulse entirely between edges must not land.
    @(negedge clk);
    #10;
    address    = 8'd7;
    write_data = 8'hee;
    wren       = 1'b0;
    #10;
    wren       = 1'b1;
    address    = 8'd9;
    @(posedge clk);
    #1;
    read_addr(8'd7, "glitch_a7");
    read_addr(8'd9, "glitch_a9");
    $display("txn glitch wren pulse between edges");

    // Reset beats a simultaneous write.
    @(negedge clk);
    #40;
    rst_n      = 1'b0;
    wren       = 1'b0;
    address    = 8'd1;
    write_data = 8'hff;
    @(posedge clk);
    model_clear();
    #1;
    sb_push(model_mem[1], "reset_priority_a1");
    sb_check();
    $display("txn reset with write addr=01 data=ff read_data=%02h", read_data);
    @(negedge clk);
    rst_n = 1'b1;
    wren  = 1'b1;
    scan_all("post_reset_clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_data_mem
